// File: rtl/mem_port_arbiter_if.sv
// One valid/ready request channel plus its in-order response channel.
// The same bundle describes a requester port and the shared memory port.
interface mem_port_arbiter_if #(
    parameter int RS_ID_WIDTH = 5
);
    logic                   valid;
    logic                   ready;
    logic [0:RS_ID_WIDTH-1] rs_id;
    logic [0:4]             reg_addr;
    logic [0:31]            address;
    logic [0:3]             write_en;
    logic [0:3]             read_en;
    logic [0:31]            write_data;

    logic                   resp_valid;
    logic                   resp_ready;
    logic [0:RS_ID_WIDTH-1] resp_rs_id;
    logic [0:4]             resp_reg_addr;
    logic [0:31]            resp_data;

    // master issues requests and consumes responses
    modport master (
        output valid, rs_id, reg_addr, address, write_en, read_en, write_data, resp_ready,
        input  ready, resp_valid, resp_rs_id, resp_reg_addr, resp_data
    );

    modport slave (
        input  valid, rs_id, reg_addr, address, write_en, read_en, write_data, resp_ready,
        output ready, resp_valid, resp_rs_id, resp_reg_addr, resp_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single in-order memory port with response routing.
// Define MEM_ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 wins); default is round-robin.
module mem_port_arbiter #(
    parameter int RS_ID_WIDTH = 5,
    parameter int DEPTH       = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  req0,
    mem_port_arbiter_if.slave  req1,
    mem_port_arbiter_if.master mem,
    output logic               busy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [0:RS_ID_WIDTH-1] rs_id;
        logic [0:4]             reg_addr;
        logic [0:31]            address;
        logic [0:3]             write_en;
        logic [0:3]             read_en;
        logic [0:31]            write_data;
    } req_t;

    req_t [1:0]       req_fields;
    req_t             mem_fields;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       resp_ready;
    logic [1:0]       resp_valid;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] order_q, order_d;
    logic             lock_q, lock_d;
    logic             lock_idx_q, lock_idx_d;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
    logic             last_grant_q, last_grant_d;
`endif

    logic full, empty, grant_vld, grant_idx, accept, pop, head_idx;

    always_comb begin
        req_fields[0] = {req0.rs_id, req0.reg_addr, req0.address,
                         req0.write_en, req0.read_en, req0.write_data};
        req_fields[1] = {req1.rs_id, req1.reg_addr, req1.address,
                         req1.write_en, req1.read_en, req1.write_data};
        req_valid     = {req1.valid, req0.valid};
        resp_ready    = {req1.resp_ready, req0.resp_ready};
    end

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A stalled grant stays locked so the memory sees a stable request.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        if (!rst && !full) begin
            if (lock_q) begin
                grant_idx = lock_idx_q;
                grant_vld = req_valid[lock_idx_q];
            end else if (req_valid[0] && req_valid[1]) begin
                grant_vld = 1'b1;
`ifdef MEM_ARB_FIXED_PRIORITY_EN
                grant_idx = 1'b0;
`else
                grant_idx = ~last_grant_q;
`endif
            end else if (req_valid[0]) begin
                grant_vld = 1'b1;
                grant_idx = 1'b0;
            end else if (req_valid[1]) begin
                grant_vld = 1'b1;
                grant_idx = 1'b1;
            end
        end
    end

    assign accept     = grant_vld & mem.ready;
    assign mem_fields = grant_vld ? req_fields[grant_idx] : '0;

    always_comb begin
        req_ready[0] = accept & (grant_idx == 1'b0);
        req_ready[1] = accept & (grant_idx == 1'b1);
    end

    assign mem.valid      = grant_vld;
    assign mem.rs_id      = mem_fields.rs_id;
    assign mem.reg_addr   = mem_fields.reg_addr;
    assign mem.address    = mem_fields.address;
    assign mem.write_en   = mem_fields.write_en;
    assign mem.read_en    = mem_fields.read_en;
    assign mem.write_data = mem_fields.write_data;
    assign req0.ready     = req_ready[0];
    assign req1.ready     = req_ready[1];

    // Responses with nothing outstanding are swallowed (ready=1, no resp_valid).
    assign head_idx       = order_q[head_q];
    assign mem.resp_ready = !rst && (empty || resp_ready[head_idx]);
    assign pop            = mem.resp_valid & mem.resp_ready & !empty;

    always_comb begin
        resp_valid[0] = !rst && mem.resp_valid && !empty && (head_idx == 1'b0);
        resp_valid[1] = !rst && mem.resp_valid && !empty && (head_idx == 1'b1);
    end

    assign req0.resp_valid    = resp_valid[0];
    assign req1.resp_valid    = resp_valid[1];
    assign req0.resp_rs_id    = mem.resp_rs_id;
    assign req1.resp_rs_id    = mem.resp_rs_id;
    assign req0.resp_reg_addr = mem.resp_reg_addr;
    assign req1.resp_reg_addr = mem.resp_reg_addr;
    assign req0.resp_data     = mem.resp_data;
    assign req1.resp_data     = mem.resp_data;

    assign busy = !rst && !empty;

    always_comb begin
        order_d = order_q;
        if (accept) order_d[tail_q] = grant_idx;
        tail_d     = tail_q + PTR_W'(accept);
        head_d     = head_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(accept) - CNT_W'(pop);
        lock_d     = grant_vld & ~mem.ready;
        lock_idx_d = grant_idx;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
        last_grant_d = accept ? grant_idx : last_grant_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            order_q      <= '0;
            lock_q       <= 1'b0;
            lock_idx_q   <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            order_q      <= order_d;
            lock_q       <= lock_d;
            lock_idx_q   <= lock_idx_d;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: arbitration, lock, full FIFO, response routing.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   g [4];

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.RS_ID_WIDTH(5)) r0_if ();
    mem_port_arbiter_if #(.RS_ID_WIDTH(5)) r1_if ();
    mem_port_arbiter_if #(.RS_ID_WIDTH(5)) m_if ();

    mem_port_arbiter #(.RS_ID_WIDTH(5), .DEPTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (r0_if.slave),
        .req1 (r1_if.slave),
        .mem  (m_if.master),
        .busy (busy)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [4:0] rs_of(input int n);
        return (n != 0) ? 5'd17 : 5'd3;
    endfunction

    function automatic logic [4:0] ra_of(input int n);
        return (n != 0) ? 5'd20 : 5'd10;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic mresp(input logic v, input int n, input logic [31:0] d);
        m_if.resp_valid    = v;
        m_if.resp_rs_id    = v ? rs_of(n) : 5'd0;
        m_if.resp_reg_addr = v ? ra_of(n) : 5'd0;
        m_if.resp_data     = d;
    endtask

    initial begin
        r0_if.rs_id = rs_of(0); r0_if.reg_addr = ra_of(0);
        r0_if.address = 32'h0000_1000; r0_if.write_en = 4'h0; r0_if.read_en = 4'hF;
        r0_if.write_data = 32'h0;
        r1_if.rs_id = rs_of(1); r1_if.reg_addr = ra_of(1);
        r1_if.address = 32'h0000_2000; r1_if.write_en = 4'hF; r1_if.read_en = 4'h0;
        r1_if.write_data = 32'hCAFE_F00D;
        r0_if.valid = 1'b1; r1_if.valid = 1'b1;
        r0_if.resp_ready = 1'b1; r1_if.resp_ready = 1'b1;
        m_if.ready = 1'b1;
        mresp(1'b1, 0, 32'h1234);
        rst = 1'b1;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
        g = '{0, 0, 0, 0};
`else
        g = '{0, 1, 0, 1};
`endif

        // reset forces handshake outputs low
        smp();
        chk("rst_mem_valid", m_if.valid, 0);
        chk("rst_req_ready0", r0_if.ready, 0);
        chk("rst_resp_valid0", r0_if.resp_valid, 0);
        chk("rst_mem_resp_ready", m_if.resp_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_addr", m_if.address, 0);
        cyc();
        rst = 1'b0;
        mresp(1'b0, 0, 0);

        // both valid: grants per g[], responses returned 2 cycles later
        for (int k = 0; k < 6; k++) begin
            if (k >= 4) begin r0_if.valid = 1'b0; r1_if.valid = 1'b0; end
            if (k >= 2) mresp(1'b1, g[k-2], 32'hD000_0000 + k);
            else        mresp(1'b0, 0, 0);
            smp();
            if (k < 4) begin
                chk($sformatf("t1_mem_rs_id_%0d", k), m_if.rs_id, rs_of(g[k]));
                chk($sformatf("t1_ready0_%0d", k), r0_if.ready, g[k] == 0);
                chk($sformatf("t1_ready1_%0d", k), r1_if.ready, g[k] == 1);
            end
            if (k >= 2) begin
                chk($sformatf("t1_resp_valid0_%0d", k), r0_if.resp_valid, g[k-2] == 0);
                chk($sformatf("t1_resp_valid1_%0d", k), r1_if.resp_valid, g[k-2] == 1);
                chk($sformatf("t1_resp_rs_%0d", k),
                    (g[k-2] == 0) ? r0_if.resp_rs_id : r1_if.resp_rs_id, rs_of(g[k-2]));
                chk($sformatf("t1_resp_ra_%0d", k),
                    (g[k-2] == 0) ? r0_if.resp_reg_addr : r1_if.resp_reg_addr, ra_of(g[k-2]));
                chk($sformatf("t1_resp_data_%0d", k), r0_if.resp_data, 32'hD000_0000 + k);
            end
            cyc();
        end
        mresp(1'b0, 0, 0);
        smp();
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_mem_valid", m_if.valid, 0);
        chk("t1_idle_mem_addr", m_if.address, 0);
        cyc();

        // lock: requester 1 stalled for 3 cycles, requester 0 joins in cycle 2
        r1_if.valid = 1'b1; m_if.ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) r0_if.valid = 1'b1;
            smp();
            chk($sformatf("t2_lock_rs_%0d", k), m_if.rs_id, 5'd17);
            chk($sformatf("t2_lock_addr_%0d", k), m_if.address, 32'h0000_2000);
            chk($sformatf("t2_lock_ready1_%0d", k), r1_if.ready, 0);
            cyc();
        end
        m_if.ready = 1'b1;
        smp();
        chk("t2_release_ready1", r1_if.ready, 1);
        chk("t2_release_ready0", r0_if.ready, 0);
        chk("t2_release_wdata", m_if.write_data, 32'hCAFE_F00D);
        cyc();
        r1_if.valid = 1'b0;
        smp();
        chk("t2_next_ready0", r0_if.ready, 1);
        cyc();
        r0_if.valid = 1'b0;
        mresp(1'b1, 1, 32'h11);
        smp();
        chk("t2_drain_valid1", r1_if.resp_valid, 1);
        chk("t2_drain_valid0a", r0_if.resp_valid, 0);
        cyc();
        mresp(1'b1, 0, 32'h22);
        smp();
        chk("t2_drain_valid0", r0_if.resp_valid, 1);
        cyc();
        mresp(1'b0, 0, 0);
        smp();
        chk("t2_drained_busy", busy, 0);
        cyc();

        // fill the FIFO with four requester-0 requests
        r0_if.valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk($sformatf("t3_fill_ready0_%0d", k), r0_if.ready, 1);
            cyc();
        end
        r1_if.valid = 1'b1;
        smp();
        chk("t3_full_mem_valid", m_if.valid, 0);
        chk("t3_full_ready0", r0_if.ready, 0);
        chk("t3_full_ready1", r1_if.ready, 0);
        chk("t3_full_busy", busy, 1);
        cyc();
        r1_if.valid = 1'b0;
        mresp(1'b1, 0, 32'h33);
        smp();
        chk("t3_pop_no_push", r0_if.ready, 0);
        chk("t3_pop_resp_valid0", r0_if.resp_valid, 1);
        cyc();
        mresp(1'b0, 0, 0);
        smp();
        chk("t3_resume_ready0", r0_if.ready, 1);
        cyc();
        r0_if.valid = 1'b0;

        // head response back-pressured for 2 cycles, then popped
        mresp(1'b1, 0, 32'h44);
        r0_if.resp_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            smp();
            chk($sformatf("t4_stall_mem_resp_ready_%0d", k), m_if.resp_ready, 0);
            chk($sformatf("t4_stall_resp_valid0_%0d", k), r0_if.resp_valid, 1);
            chk($sformatf("t4_stall_mem_valid_%0d", k), m_if.valid, 0);
            cyc();
        end
        r0_if.resp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk($sformatf("t4_drain_mem_resp_ready_%0d", k), m_if.resp_ready, 1);
            chk($sformatf("t4_drain_busy_%0d", k), busy, 1);
            cyc();
        end
        mresp(1'b0, 0, 0);
        smp();
        chk("t4_empty_busy", busy, 0);
        cyc();

        // unexpected response on an empty FIFO is swallowed
        mresp(1'b1, 1, 32'h55);
        smp();
        chk("t5_unexp_mem_resp_ready", m_if.resp_ready, 1);
        chk("t5_unexp_resp_valid0", r0_if.resp_valid, 0);
        chk("t5_unexp_resp_valid1", r1_if.resp_valid, 0);
        cyc();
        mresp(1'b0, 0, 0);
        smp();
        chk("t5_unexp_busy", busy, 0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one data-memory/D-cache request port between two load/store requesters, e.g. the load/store unit and a second memory client such as a fetch or writeback path. Each cycle the block grants one requester onto the memory port using round-robin arbitration. It records every granted request in an in-order ordering FIFO. It routes each in-order memory response back to the requester that issued it, together with that request's rs_id and reg_addr tags.

## Interface
- RS_ID_WIDTH, 5, width of reservation-station ID tag
- DEPTH, 4, maximum outstanding requests (power of two, ≥2); ordering FIFO size

Ports (n = 0, 1; bit 0 is MSB, big-endian vectors):
- clk  in  1  clock
- rst  in  1  reset, synchronous and active-high
- req_valid_n  in  1  requester n presents a request
- req_ready_n  out  1  requester n's request accepted this cycle
- req_rs_id_n  in  RS_ID_WIDTH  tag carried with the request
- req_reg_addr_n  in  5  tag carried with the request
- req_address_n  in  32  byte address
- req_write_en_n  in  4  byte write enables
- req_read_en_n  in  4  byte read enables
- req_write_data_n  in  32  store data
- resp_valid_n  out  1  response for requester n
- resp_ready_n  in  1  requester n accepts the response
- resp_rs_id_n  out  RS_ID_WIDTH  returned tag
- resp_reg_addr_n  out  5  returned tag
- resp_data_n  out  32  read data
- mem_req_valid, mem_req_ready  out/in  1  memory request handshake
- mem_rs_id, mem_reg_addr, mem_address, mem_write_en, mem_read_en, mem_write_data  out  as above  muxed request fields
- mem_resp_valid, mem_resp_ready  in/out  1  memory response handshake
- mem_resp_rs_id, mem_resp_reg_addr, mem_resp_data  in  as above  response fields
- busy  out  1  ordering FIFO non-empty

## Operation
- Handshakes are valid/ready. A transfer occurs when both are high at the clock edge. A requester must hold valid and all fields stable until accepted.
- Memory contract:
  - exactly one response per request, loads and stores alike;
  - responses arrive in request order;
  - response latency is at least 1 cycle.
- Grant selection:
  - If the FIFO is full (count == DEPTH), there is no grant, and mem_req_valid = 0.
  - If one requester is valid, grant it.
  - If both are valid, grant the requester not in last_grant_ff.
- Grant lock:
  - If mem_req_valid = 1 and mem_req_ready = 0, lock_ff holds the current grant. The grant stays there next cycle even if the other requester becomes eligible.
  - The lock releases on acceptance.
- mem_* request fields = the granted requester's fields. With no grant, they are 0.
- req_ready_n = grant_n & mem_req_ready & !full.
- On request acceptance:
  - push the requester index into the FIFO;
  - last_grant_ff <= granted index.
- Response routing:
  - head = FIFO head index.
  - resp_valid_head = mem_resp_valid & !empty; the other resp_valid is 0.
  - mem_resp_ready = resp_ready_head.
  - Response fields are passed through to both requesters.
  - Pop on mem_resp_valid & mem_resp_ready.
- Unexpected response (mem_resp_valid while the FIFO is empty): mem_resp_ready = 1, and the response is discarded. No resp_valid is raised.
- Push and pop in the same cycle: count is unchanged, and both pointers advance modulo DEPTH.
- Full check uses the registered count only; a same-cycle pop does not enable a push.

## Timing
- Request and response paths are combinational, so arbitration adds zero cycles. A push is visible to the response side from the next cycle.
- Reset:
  - FIFO is emptied (pointers and count = 0);
  - last_grant_ff = 1, so requester 0 wins the first conflict;
  - lock_ff cleared;
  - all valid/ready outputs forced to 0 while rst = 1, and busy = 0.
- Reset mid-operation drops all outstanding entries. The memory must be reset together with this block. Any late responses are discarded as unexpected.
- Throughput: one request and one response per cycle sustained while count < DEPTH.

## Configuration
- MEM_ARB_FIXED_PRIORITY_EN:
  - Defined: requester 0 always wins a conflict. last_grant_ff is not implemented. The grant lock still applies.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset, then both requesters valid every cycle with mem_req_ready = 1 → grants alternate 0,1,0,1; mem_resp returned in order after 2 cycles reaches the matching requester with correct rs_id and reg_addr.
- mem_req_ready = 0 for 3 cycles while requester 1 is granted and requester 0 asserts valid in cycle 2 → grant stays on requester 1 until acceptance; requester 0 is granted next.
- DEPTH = 4, 4 requests accepted with no responses → count = 4, mem_req_valid = 0 and both req_ready = 0; one response popped → next-cycle grant resumes.
- Head response with resp_ready_head = 0 for 2 cycles → mem_resp_ready = 0, response fields held by memory, no pop; pop on the third cycle.
- mem_resp_valid with an empty FIFO → mem_resp_ready = 1, both resp_valid = 0, count stays 0.
- With MEM_ARB_FIXED_PRIORITY_EN defined, both valid for 4 cycles → requester 0 wins all 4.
